// File: rtl/sram_access_arbiter.sv
// Two-port arbiter in front of a single-port SRAM: port 0 has priority, a burst counter bounds how long port 1 waits.
// Optional macro SRAM_ARB_WRITE_PROTECT_EN drops port-1 writes at or above PROTECT_BASE and flags them on req1_err.
module sram_access_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
`ifdef SRAM_ARB_WRITE_PROTECT_EN
  , parameter logic [ADDR_W-1:0] PROTECT_BASE = 7'h70
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_err,
  output logic              mem_en,
  output logic              mem_re_weN,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        state_dbg
);

  // valid/ready: an access is accepted in the cycle where valid && ready; the
  // requester keeps valid/we/addr/wdata stable until then. ready is combinational.
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_e              state_q, state_d;
  logic [3:0]          burst_q, burst_d;
  logic                grant0, grant1, acc_we, drop, issue;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic                mem_en_q, mem_re_weN_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                rd_pend_q, rd_own1_q;
  logic                rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;

  always_comb begin
    grant0    = req0_valid && (!req1_valid || (burst_q < MAX_B));
    grant1    = req1_valid && !grant0;
    acc_we    = grant0 ? req0_we    : req1_we;
    acc_addr  = grant0 ? req0_addr  : req1_addr;
    acc_wdata = grant0 ? req0_wdata : req1_wdata;
`ifdef SRAM_ARB_WRITE_PROTECT_EN
    drop      = grant1 && req1_we && (req1_addr >= PROTECT_BASE);
`else
    drop      = 1'b0;
`endif
    issue     = (grant0 || grant1) && !drop;

    state_d = IDLE;
    if (grant0)      state_d = OWN0;
    else if (grant1) state_d = OWN1;

    // Count only port-0 wins that make a waiting port 1 wait longer.
    burst_d = burst_q;
    if (!req1_valid || grant1)        burst_d = 4'd0;
    else if (grant0 && burst_q != MAX_B) burst_d = burst_q + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      burst_q      <= 4'd0;
      mem_en_q     <= 1'b0;
      mem_re_weN_q <= 1'b1;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_pend_q    <= 1'b0;
      rd_own1_q    <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      mem_en_q <= issue;
      if (issue) begin
        mem_re_weN_q <= ~acc_we;
        mem_addr_q   <= acc_addr;
        mem_wdata_q  <= acc_wdata;
      end
      // Tag the read with the owner of the issue cycle; data arrives one cycle later.
      rd_pend_q <= mem_en_q && mem_re_weN_q;
      rd_own1_q <= (state_q == OWN1);
      rvalid0_q <= rd_pend_q && !rd_own1_q;
      rvalid1_q <= rd_pend_q && rd_own1_q;
      if (rd_pend_q && !rd_own1_q) rdata0_q <= mem_rdata;
      if (rd_pend_q && rd_own1_q)  rdata1_q <= mem_rdata;
    end
  end

`ifdef SRAM_ARB_WRITE_PROTECT_EN
  logic err_q;
  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= drop;
  end
  assign req1_err = err_q;
`else
  assign req1_err = 1'b0;
`endif

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign req0_rvalid = rvalid0_q;
  assign req1_rvalid = rvalid1_q;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;
  assign mem_en      = mem_en_q;
  assign mem_re_weN  = mem_re_weN_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign state_dbg   = state_q;

endmodule
